// File: rtl/ofmap_wb_pkg.sv
// Shared types and constants for the ofmap write-back stage.
package ofmap_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned ROWS_PER_TILE_DEF = 294;
    localparam int unsigned TILE_NUM_DEF      = 5;
    localparam int unsigned TOTAL_ROWS_DEF    = ROWS_PER_TILE_DEF * TILE_NUM_DEF;

    function automatic int unsigned total_rows(input int unsigned rows_per_tile,
                                               input int unsigned tile_num);
        return rows_per_tile * tile_num;
    endfunction

endpackage

// File: rtl/ofmap_wb_relu_lane.sv
// Combinational single-lane ReLU on a signed two's-complement value.
module relu_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  relu_en,
    input  logic [DATA_WIDTH-1:0] lane_in,
    output logic [DATA_WIDTH-1:0] lane_out
);

    always_comb begin
        lane_out = lane_in;
        if (relu_en && lane_in[DATA_WIDTH-1])
            lane_out = '0;
    end

endmodule

// File: rtl/ofmap_wb.sv
// Ofmap write-back: optional ReLU, linear output-buffer addressing by
// row-within-tile then tile, and a layer-done pulse.
module ofmap_wb
    import ofmap_wb_pkg::*;
#(
    parameter int PE_SIZE       = 14,
    parameter int DATA_WIDTH    = 8,
    parameter int ROWS_PER_TILE = 294,
    parameter int TILE_NUM      = 5,
    parameter int ADDR_WIDTH    = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          relu_en_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    output logic                          wr_en_o,
    output logic [ADDR_WIDTH-1:0]         wr_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] wr_data_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int unsigned TOTAL = total_rows(ROWS_PER_TILE, TILE_NUM);
    localparam int RW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
    localparam int TW = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

    state_t                          state;
    logic [RW-1:0]                   row_cnt;
    logic [TW-1:0]                   tile_cnt;
    logic [ADDR_WIDTH-1:0]           base;
    logic                            relu_q;
    logic [ADDR_WIDTH-1:0]           addr_cur;
    logic                            last_row;
    logic                            row_wrap;
    logic [DATA_WIDTH*PE_SIZE-1:0]   relu_row;

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        relu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
            .relu_en  (relu_q),
            .lane_in  (ofmap_row_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .lane_out (relu_row[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Address is base + row_cnt; base advances by one tile on each row wrap.
    always_comb begin
        addr_cur = base + ADDR_WIDTH'(row_cnt);
        last_row = (addr_cur == ADDR_WIDTH'(TOTAL - 1));
        row_wrap = (row_cnt == RW'(ROWS_PER_TILE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            row_cnt   <= '0;
            tile_cnt  <= '0;
            base      <= '0;
            relu_q    <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state    <= ST_RUN;
                        row_cnt  <= '0;
                        tile_cnt <= '0;
                        base     <= '0;
                        relu_q   <= relu_en_i;
                        err_o    <= 1'b0;
                        busy_o   <= 1'b1;
                    end else if (ofmap_valid_i) begin
                        err_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ofmap_valid_i) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= addr_cur;
                        wr_data_o <= relu_row;
                        if (last_row) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else if (row_wrap) begin
                            row_cnt  <= '0;
                            tile_cnt <= tile_cnt + 1'b1;
                            base     <= base + ADDR_WIDTH'(ROWS_PER_TILE);
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (ofmap_valid_i)
                        err_o <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofmap_wb.sv
// Directed self-checking bench for ofmap_wb with a 4-row x 2-tile layer.
module tb_ofmap_wb;

    localparam int PE   = 14;
    localparam int DW   = 8;
    localparam int RPT  = 4;
    localparam int TN   = 2;
    localparam int AW   = 11;
    localparam int NROW = RPT * TN;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              relu_en_i;
    logic [DW*PE-1:0]  ofmap_row_i;
    logic              ofmap_valid_i;
    logic              wr_en_o;
    logic [AW-1:0]     wr_addr_o;
    logic [DW*PE-1:0]  wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int tests_run = 0;
    int tests_failed = 0;

    ofmap_wb #(
        .PE_SIZE       (PE),
        .DATA_WIDTH    (DW),
        .ROWS_PER_TILE (RPT),
        .TILE_NUM      (TN),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .relu_en_i     (relu_en_i),
        .ofmap_row_i   (ofmap_row_i),
        .ofmap_valid_i (ofmap_valid_i),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW*PE-1:0] fill(input logic [7:0] v);
        logic [DW*PE-1:0] r;
        for (int k = 0; k < PE; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    // Lane k cycles through 80,7F,FF,01 offset by row; ReLU result 00,7F,00,01.
    function automatic logic [DW*PE-1:0] relu_pat(input int row, input bit clipped);
        logic [DW*PE-1:0] r;
        logic [7:0] raw [4];
        logic [7:0] cut [4];
        raw = '{8'h80, 8'h7F, 8'hFF, 8'h01};
        cut = '{8'h00, 8'h7F, 8'h00, 8'h01};
        for (int k = 0; k < PE; k++)
            r[k*DW +: DW] = clipped ? cut[(k + row) % 4] : raw[(k + row) % 4];
        return r;
    endfunction

    task automatic check_write(input string tag, input int addr, input logic [DW*PE-1:0] data,
                               input bit last);
        chk({tag, "_wr_en"}, 128'(wr_en_o), 128'(1'b1));
        chk({tag, "_addr"},  128'(wr_addr_o), 128'(addr));
        chk({tag, "_data"},  128'(wr_data_o), 128'(data));
        chk({tag, "_done"},  128'(done_o), 128'(last));
        chk({tag, "_busy"},  128'(busy_o), 128'(!last));
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        relu_en_i = 1'b0;
        ofmap_row_i = '0;
        ofmap_valid_i = 1'b0;
        #12;
        chk("rst_wr_en", 128'(wr_en_o), 128'(0));
        chk("rst_addr",  128'(wr_addr_o), 128'(0));
        chk("rst_data",  128'(wr_data_o), 128'(0));
        chk("rst_busy",  128'(busy_o), 128'(0));
        chk("rst_done",  128'(done_o), 128'(0));
        chk("rst_err",   128'(err_o), 128'(0));
        rst = 1'b0;
        tick();

        // Nominal layer, no ReLU.
        start_i = 1'b1;
        relu_en_i = 1'b0;
        tick();
        start_i = 1'b0;
        chk("nom_busy_after_start", 128'(busy_o), 128'(1));
        chk("nom_no_wr_at_start", 128'(wr_en_o), 128'(0));
        for (int r = 0; r < NROW; r++) begin
            ofmap_valid_i = 1'b1;
            ofmap_row_i = fill(8'(r));
            tick();
            check_write($sformatf("nom%0d", r), r, fill(8'(r)), r == NROW - 1);
        end

        // DONE cycle: start here is ignored, one cycle later it is accepted.
        ofmap_valid_i = 1'b0;
        start_i = 1'b1;
        relu_en_i = 1'b1;
        tick();
        chk("b2b_ign_busy", 128'(busy_o), 128'(0));
        chk("b2b_ign_done", 128'(done_o), 128'(0));
        chk("b2b_ign_wr_en", 128'(wr_en_o), 128'(0));
        chk("nom_hold_addr", 128'(wr_addr_o), 128'(7));
        chk("nom_hold_data", 128'(wr_data_o), 128'(fill(8'd7)));
        tick();
        start_i = 1'b0;
        chk("b2b_acc_busy", 128'(busy_o), 128'(1));

        // ReLU layer; relu_en_i toggled mid-layer must not matter.
        for (int r = 0; r < NROW; r++) begin
            if (r == 3) relu_en_i = 1'b0;
            if (r == 5) relu_en_i = 1'b1;
            ofmap_valid_i = 1'b1;
            ofmap_row_i = relu_pat(r, 1'b0);
            tick();
            check_write($sformatf("relu%0d", r), r, relu_pat(r, 1'b1), r == NROW - 1);
        end
        ofmap_valid_i = 1'b0;
        tick();
        tick();

        // Valid while IDLE: dropped and flagged.
        ofmap_valid_i = 1'b1;
        ofmap_row_i = fill(8'hAA);
        tick();
        chk("idle_valid_no_wr", 128'(wr_en_o), 128'(0));
        chk("idle_valid_err", 128'(err_o), 128'(1));
        ofmap_valid_i = 1'b0;
        tick();
        chk("err_sticky", 128'(err_o), 128'(1));

        // Start with simultaneous valid: row dropped, err cleared.
        start_i = 1'b1;
        relu_en_i = 1'b0;
        ofmap_valid_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_clr_err", 128'(err_o), 128'(0));
        chk("start_valid_no_wr", 128'(wr_en_o), 128'(0));

        // Gapped rows; a start during RUN at row 3 is ignored.
        begin
            int done_cnt = 0;
            for (int r = 0; r < NROW; r++) begin
                ofmap_valid_i = 1'b0;
                tick();
                chk($sformatf("gap%0d_no_wr", r), 128'(wr_en_o), 128'(0));
                if (done_o) done_cnt++;
                ofmap_valid_i = 1'b1;
                start_i = (r == 3);
                ofmap_row_i = fill(8'(r + 16));
                tick();
                start_i = 1'b0;
                check_write($sformatf("gap%0d", r), r, fill(8'(r + 16)), r == NROW - 1);
                if (done_o) done_cnt++;
            end
            ofmap_valid_i = 1'b0;
            tick();
            if (done_o) done_cnt++;
            tick();
            if (done_o) done_cnt++;
            chk("gap_done_once", 128'(done_cnt), 128'(1));
            chk("gap_no_err", 128'(err_o), 128'(0));
        end

        // Reset mid-layer after row 5.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int r = 0; r < 6; r++) begin
            ofmap_valid_i = 1'b1;
            ofmap_row_i = fill(8'(r + 32));
            tick();
        end
        chk("pre_rst_addr", 128'(wr_addr_o), 128'(5));
        ofmap_valid_i = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 128'(wr_en_o), 128'(0));
        chk("mid_rst_addr",  128'(wr_addr_o), 128'(0));
        chk("mid_rst_data",  128'(wr_data_o), 128'(0));
        chk("mid_rst_busy",  128'(busy_o), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int r = 0; r < NROW; r++) begin
            ofmap_valid_i = 1'b1;
            ofmap_row_i = fill(8'(r + 48));
            tick();
            check_write($sformatf("post_rst%0d", r), r, fill(8'(r + 48)), r == NROW - 1);
        end
        ofmap_valid_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ofmap_wb.md
# ofmap_wb

Ofmap write-back stage placed directly downstream of the partial-sum accumulator (`ACC_v2`). It consumes the quantized `PE_SIZE`-lane ofmap rows that the accumulator emits with a valid strobe. It optionally applies per-lane ReLU and generates linear output-buffer addresses, walking rows within a column tile and then advancing tiles. It signals layer completion with a one-cycle done pulse.

## Interface
- `PE_SIZE`, 14, lanes per ofmap row (systolic array width)
- `DATA_WIDTH`, 8, bits per lane, signed two's complement
- `ROWS_PER_TILE`, 294, ofmap rows per column tile (= weight row count)
- `TILE_NUM`, 5, column tiles per layer (= ceil(70/`PE_SIZE`))
- `ADDR_WIDTH`, 11, output-buffer address width; must satisfy 2^`ADDR_WIDTH` >= `ROWS_PER_TILE`*`TILE_NUM`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  arm for one layer; sampled only in IDLE
- `relu_en_i`  in  1  ReLU enable; captured on accepted `start_i` and held for the layer
- `ofmap_row_i`  in  `DATA_WIDTH`*`PE_SIZE`  row from accumulator; lane k = bits [k*`DATA_WIDTH` +: `DATA_WIDTH`]
- `ofmap_valid_i`  in  1  row valid; no backpressure, so every valid row in RUN is written
- `wr_en_o`  out  1  output-buffer write strobe
- `wr_addr_o`  out  `ADDR_WIDTH`  write address
- `wr_data_o`  out  `DATA_WIDTH`*`PE_SIZE`  write data
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  one-cycle pulse, layer complete
- `err_o`  out  1  sticky; valid row arrived outside RUN

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start_i`. Clears row/tile counters and `err_o`, and latches `relu_en_i`.
  - RUN -> DONE on the cycle the final row (row `ROWS_PER_TILE`-1, tile `TILE_NUM`-1) is accepted.
  - DONE -> IDLE unconditionally after one cycle.
- `start_i` in RUN or DONE is ignored; no restart and no counter change.
- Row acceptance in RUN:
  - Each `ofmap_valid_i`=1 cycle accepts one row.
  - Address = tile_cnt*`ROWS_PER_TILE` + row_cnt, computed incrementally with a base register, no multiplier.
  - row_cnt wraps from `ROWS_PER_TILE`-1 to 0. On the wrap, tile_cnt increments and base += `ROWS_PER_TILE`.
- Gaps in `ofmap_valid_i` are allowed; counters hold.
- ReLU, when enabled: each lane is treated as signed, and any lane with MSB=1 is forced to 0; other lanes pass unchanged. When disabled, data passes bit-exact.
- Valid in IDLE or DONE: the row is dropped, no write occurs, and `err_o` sets and stays set until the next accepted `start_i` or `rst`.
- Valid on the same cycle as an accepted `start_i` (in IDLE): dropped, and `err_o` is left cleared by the start.

## Timing
- Reset values: state=IDLE, `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, counters=0, latched relu=0.
- Latency: a row accepted at edge t appears registered as `wr_en_o`/`wr_addr_o`/`wr_data_o` during cycle t+1 (one pipeline stage). All outputs are registered.
- `done_o` is high in the same cycle as the final `wr_en_o` pulse (both registered from the final acceptance edge). `busy_o` drops in that same cycle.
- `wr_addr_o` and `wr_data_o` hold their last value when `wr_en_o`=0.
- Back-to-back rows sustain one write per cycle with no bubble across tile wrap.
- `rst` mid-layer: all outputs and state return to reset values asynchronously. A pending write is discarded.

## Structure
- The shared package holds the FSM state enum (IDLE/RUN/DONE, 2-bit encoding) and a localparam for the total row count `ROWS_PER_TILE`*`TILE_NUM`. These are reused by the top-level controller.
- One sub-module, `relu_lane`: a combinational per-lane ReLU, instantiated `PE_SIZE` times by generate.
- Counters, FSM and the output register stage live in `ofmap_wb`.

## Test plan
All scenarios use `ROWS_PER_TILE`=4, `TILE_NUM`=2, `PE_SIZE`=14.

- **Nominal:** start with relu=0, then 8 consecutive valid rows with all lanes = row index -> writes at addr 0..7 with data equal to input, one cycle late; `done_o` pulses with the write to addr 7; `busy_o` falls there.
- **ReLU:** start with relu=1; rows with lanes alternating 8'h80, 8'h7F, 8'hFF, 8'h01 -> written lanes 00, 7F, 00, 01. Toggling `relu_en_i` mid-layer has no effect.
- **Gapped valid:** valid on alternate cycles for 8 rows -> addresses still 0..7 contiguous; tile wrap at row 4 gives addr 4; `done_o` is exactly one pulse.
- **Error and ignore:** valid while IDLE -> no write, `err_o`=1; next start clears it. `start_i` during RUN at row 3 -> counters unchanged, addr continues at 4.
- **Reset mid-op:** assert `rst` after row 5 -> all outputs 0 immediately. A new start plus 8 rows writes from addr 0 again.
- **Back-to-back layers:** start asserted in the DONE cycle is ignored; start one cycle later is accepted and the addresses restart at 0.
